// File: rtl/cache_sa_rr.sv
`default_nettype none
// ============================================================================
// Module   : cache_sa_rr
// Purpose  : Set-associative, write-through, no-write-allocate data cache with
//            one outstanding request, round-robin arbitration across LSU
//            channels and per-set victim rotation. Optional statistics
//            counters are built when CACHE_STATS_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module cache_sa_rr #(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 8,
    parameter int CHANNELS  = 4,
    parameter int SETS      = 8,
    parameter int WAYS      = 2
) (
    input  logic                            clk,
    input  logic                            reset,
`ifdef CACHE_STATS_EN
    output logic [15:0]                     stat_hits,
    output logic [15:0]                     stat_misses,
    output logic [15:0]                     stat_writes,
`endif
    input  logic [CHANNELS-1:0]             cons_read_valid,
    input  logic [CHANNELS*ADDR_BITS-1:0]   cons_read_address,
    output logic [CHANNELS-1:0]             cons_read_ready,
    output logic [CHANNELS*DATA_BITS-1:0]   cons_read_data,
    input  logic [CHANNELS-1:0]             cons_write_valid,
    input  logic [CHANNELS*ADDR_BITS-1:0]   cons_write_address,
    input  logic [CHANNELS*DATA_BITS-1:0]   cons_write_data,
    output logic [CHANNELS-1:0]             cons_write_ready,
    output logic                            mem_read_valid,
    output logic [ADDR_BITS-1:0]            mem_read_address,
    input  logic                            mem_read_ready,
    input  logic [DATA_BITS-1:0]            mem_read_data,
    output logic                            mem_write_valid,
    output logic [ADDR_BITS-1:0]            mem_write_address,
    output logic [DATA_BITS-1:0]            mem_write_data,
    input  logic                            mem_write_ready
);

    localparam int SET_BITS = $clog2(SETS);
    localparam int TAG_BITS = ADDR_BITS - SET_BITS;
    localparam int CH_BITS  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int WAY_BITS = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOOKUP  = 3'd1,
        S_MEM_RD  = 3'd2,
        S_MEM_WR  = 3'd3,
        S_RESPOND = 3'd4,
        S_RELEASE = 3'd5
    } state_t;

    state_t                 r_state;
    logic [CH_BITS-1:0]     r_last_grant;
    logic [CH_BITS-1:0]     r_ch;
    logic                   r_is_rd;
    logic [ADDR_BITS-1:0]   r_addr;
    logic [DATA_BITS-1:0]   r_wdata;
    logic                   r_hit;
    logic [WAY_BITS-1:0]    r_hit_way;

    logic [WAYS-1:0]        r_valid  [SETS];
    logic [TAG_BITS-1:0]    r_tag    [SETS][WAYS];
    logic [DATA_BITS-1:0]   r_data   [SETS][WAYS];
    logic [WAY_BITS-1:0]    r_victim [SETS];

    logic                   w_found;
    logic [CH_BITS-1:0]     w_gidx;
    logic [SET_BITS-1:0]    w_set;
    logic [TAG_BITS-1:0]    w_tag;
    logic                   w_hit;
    logic [WAY_BITS-1:0]    w_hit_way;
    logic                   w_has_inv;
    logic [WAY_BITS-1:0]    w_inv_way;
    logic [WAY_BITS-1:0]    w_vic;
    logic [WAY_BITS-1:0]    w_vic_next;
    logic                   w_held;
    logic                   w_fill;
    logic                   w_upd;

    // Round-robin scan starting just after the last granted channel; the
    // descending loop lets the nearest requester overwrite farther ones.
    always_comb begin
        int idx;
        idx     = 0;
        w_found = 1'b0;
        w_gidx  = '0;
        for (int k = CHANNELS; k >= 1; k--) begin
            idx = (int'(r_last_grant) + k) % CHANNELS;
            if (cons_read_valid[idx] || cons_write_valid[idx]) begin
                w_found = 1'b1;
                w_gidx  = CH_BITS'(idx);
            end
        end
    end

    assign w_set = r_addr[SET_BITS-1:0];
    assign w_tag = r_addr[ADDR_BITS-1:SET_BITS];

    always_comb begin
        w_hit     = 1'b0;
        w_hit_way = '0;
        w_has_inv = 1'b0;
        w_inv_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (r_valid[w_set][w] && (r_tag[w_set][w] == w_tag)) begin
                w_hit     = 1'b1;
                w_hit_way = WAY_BITS'(w);
            end
            if (!r_valid[w_set][w]) begin
                w_has_inv = 1'b1;
                w_inv_way = WAY_BITS'(w);
            end
        end
    end

    assign w_vic      = w_has_inv ? w_inv_way : r_victim[w_set];
    assign w_vic_next = (r_victim[w_set] == WAY_BITS'(WAYS - 1)) ? '0
                                                                 : r_victim[w_set] + 1'b1;
    assign w_held     = r_is_rd ? cons_read_valid[r_ch] : cons_write_valid[r_ch];
    assign w_fill     = (r_state == S_MEM_RD) && mem_read_ready;
    assign w_upd      = (r_state == S_MEM_WR) && mem_write_ready && r_hit;

    // Tag/data storage carries no reset; only the valid bits gate its use.
    always_ff @(posedge clk) begin
        if (w_fill) begin
            r_tag[w_set][w_vic]  <= w_tag;
            r_data[w_set][w_vic] <= mem_read_data;
        end else if (w_upd) begin
            r_data[w_set][r_hit_way] <= r_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state           <= S_IDLE;
            r_last_grant      <= CH_BITS'(CHANNELS - 1);
            r_ch              <= '0;
            r_is_rd           <= 1'b0;
            r_addr            <= '0;
            r_wdata           <= '0;
            r_hit             <= 1'b0;
            r_hit_way         <= '0;
            cons_read_ready   <= '0;
            cons_read_data    <= '0;
            cons_write_ready  <= '0;
            mem_read_valid    <= 1'b0;
            mem_read_address  <= '0;
            mem_write_valid   <= 1'b0;
            mem_write_address <= '0;
            mem_write_data    <= '0;
            for (int s = 0; s < SETS; s++) begin
                r_valid[s]  <= '0;
                r_victim[s] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_ch         <= w_gidx;
                        r_last_grant <= w_gidx;
                        r_is_rd      <= cons_read_valid[w_gidx];
                        r_addr       <= cons_read_valid[w_gidx]
                                      ? cons_read_address[w_gidx*ADDR_BITS +: ADDR_BITS]
                                      : cons_write_address[w_gidx*ADDR_BITS +: ADDR_BITS];
                        r_wdata      <= cons_write_data[w_gidx*DATA_BITS +: DATA_BITS];
                        r_state      <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    r_hit     <= w_hit;
                    r_hit_way <= w_hit_way;
                    if (r_is_rd && w_hit) begin
                        cons_read_ready[r_ch] <= 1'b1;
                        cons_read_data[r_ch*DATA_BITS +: DATA_BITS] <= r_data[w_set][w_hit_way];
                        r_state <= S_RESPOND;
                    end else if (r_is_rd) begin
                        mem_read_valid   <= 1'b1;
                        mem_read_address <= r_addr;
                        r_state          <= S_MEM_RD;
                    end else begin
                        mem_write_valid   <= 1'b1;
                        mem_write_address <= r_addr;
                        mem_write_data    <= r_wdata;
                        r_state           <= S_MEM_WR;
                    end
                end
                S_MEM_RD: begin
                    if (mem_read_ready) begin
                        mem_read_valid       <= 1'b0;
                        r_valid[w_set][w_vic] <= 1'b1;
                        if (!w_has_inv) begin
                            r_victim[w_set] <= w_vic_next;
                        end
                        cons_read_ready[r_ch] <= 1'b1;
                        cons_read_data[r_ch*DATA_BITS +: DATA_BITS] <= mem_read_data;
                        r_state <= S_RESPOND;
                    end
                end
                S_MEM_WR: begin
                    if (mem_write_ready) begin
                        mem_write_valid        <= 1'b0;
                        cons_write_ready[r_ch] <= 1'b1;
                        r_state                <= S_RESPOND;
                    end
                end
                S_RESPOND: begin
                    cons_read_ready  <= '0;
                    cons_write_ready <= '0;
                    r_state          <= S_RELEASE;
                end
                S_RELEASE: begin
                    // Hold off re-arbitration until the served request drops.
                    if (!w_held) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef CACHE_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_hits   <= '0;
            stat_misses <= '0;
            stat_writes <= '0;
        end else if (r_state == S_LOOKUP) begin
            if (r_is_rd && w_hit) begin
                if (stat_hits != 16'hFFFF) stat_hits <= stat_hits + 16'd1;
            end else if (r_is_rd) begin
                if (stat_misses != 16'hFFFF) stat_misses <= stat_misses + 16'd1;
            end else begin
                if (stat_writes != 16'hFFFF) stat_writes <= stat_writes + 16'd1;
            end
        end
    end
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule
`default_nettype wire

// File: tb/tb_cache_sa_rr.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_sa_rr
// Purpose  : Directed self-checking bench for cache_sa_rr (default build).
// Revision : 1.0 - initial release
// ============================================================================
module tb_cache_sa_rr;

    localparam int AB      = 8;
    localparam int DB      = 8;
    localparam int CH      = 4;
    localparam int RD_LAT  = 3;
    localparam int WR_LAT  = 2;

    logic               clk;
    logic               reset;
    logic [CH-1:0]      cons_read_valid;
    logic [CH*AB-1:0]   cons_read_address;
    logic [CH-1:0]      cons_read_ready;
    logic [CH*DB-1:0]   cons_read_data;
    logic [CH-1:0]      cons_write_valid;
    logic [CH*AB-1:0]   cons_write_address;
    logic [CH*DB-1:0]   cons_write_data;
    logic [CH-1:0]      cons_write_ready;
    logic               mem_read_valid;
    logic [AB-1:0]      mem_read_address;
    logic               mem_read_ready;
    logic [DB-1:0]      mem_read_data;
    logic               mem_write_valid;
    logic [AB-1:0]      mem_write_address;
    logic [DB-1:0]      mem_write_data;
    logic               mem_write_ready;

    int                 n_checks;
    int                 n_fail;
    int                 n_mem_rd;
    int                 n_mem_wr;
    logic [AB-1:0]      last_wr_addr;
    logic [DB-1:0]      last_wr_data;
    logic [DB-1:0]      mem_model [256];

    cache_sa_rr dut (
        .clk                (clk),
        .reset              (reset),
        .cons_read_valid    (cons_read_valid),
        .cons_read_address  (cons_read_address),
        .cons_read_ready    (cons_read_ready),
        .cons_read_data     (cons_read_data),
        .cons_write_valid   (cons_write_valid),
        .cons_write_address (cons_write_address),
        .cons_write_data    (cons_write_data),
        .cons_write_ready   (cons_write_ready),
        .mem_read_valid     (mem_read_valid),
        .mem_read_address   (mem_read_address),
        .mem_read_ready     (mem_read_ready),
        .mem_read_data      (mem_read_data),
        .mem_write_valid    (mem_write_valid),
        .mem_write_address  (mem_write_address),
        .mem_write_data     (mem_write_data),
        .mem_write_ready    (mem_write_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory responder: ready on the LAT-th cycle that valid has been seen.
    initial begin
        int rd_cnt;
        int wr_cnt;
        rd_cnt = 0;
        wr_cnt = 0;
        forever begin
            @(negedge clk);
            if (mem_read_valid) begin
                rd_cnt++;
                if (rd_cnt == RD_LAT) begin
                    mem_read_ready = 1'b1;
                    mem_read_data  = mem_model[mem_read_address];
                    n_mem_rd++;
                end else begin
                    mem_read_ready = 1'b0;
                end
            end else begin
                rd_cnt         = 0;
                mem_read_ready = 1'b0;
            end
            if (mem_write_valid) begin
                wr_cnt++;
                if (wr_cnt == WR_LAT) begin
                    mem_write_ready = 1'b1;
                    mem_model[mem_write_address] = mem_write_data;
                    last_wr_addr = mem_write_address;
                    last_wr_data = mem_write_data;
                    n_mem_wr++;
                end else begin
                    mem_write_ready = 1'b0;
                end
            end else begin
                wr_cnt          = 0;
                mem_write_ready = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic apply_reset();
        reset              = 1'b1;
        cons_read_valid    = '0;
        cons_write_valid   = '0;
        cons_read_address  = '0;
        cons_write_address = '0;
        cons_write_data    = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Issues one request on a channel, waits for its ready, then drops it
    // long enough for the cache to leave RELEASE. lat = -1 on timeout.
    task automatic do_op(input int ch, input bit wr, input logic [7:0] addr,
                         input logic [7:0] wdata, output logic [7:0] rdata,
                         output int lat, output int mrv, output bit pulse_ok);
        logic [CH-1:0] others;
        lat = -1;
        mrv = 0;
        pulse_ok = 1'b0;
        if (wr) begin
            cons_write_address[ch*AB +: AB] = addr;
            cons_write_data[ch*DB +: DB]    = wdata;
            cons_write_valid[ch]            = 1'b1;
        end else begin
            cons_read_address[ch*AB +: AB] = addr;
            cons_read_valid[ch]            = 1'b1;
        end
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            if (mem_read_valid) mrv++;
            if (wr ? cons_write_ready[ch] : cons_read_ready[ch]) begin
                lat = n;
                break;
            end
        end
        rdata  = cons_read_data[ch*DB +: DB];
        others = cons_read_ready | cons_write_ready;
        others[ch] = 1'b0;
        pulse_ok = (others == '0);
        cons_read_valid[ch]  = 1'b0;
        cons_write_valid[ch] = 1'b0;
        @(negedge clk);
        if (cons_read_ready[ch] || cons_write_ready[ch]) pulse_ok = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cons_read_valid  = '1;
        cons_write_valid = '1;
        @(negedge clk);
        n_checks++;
        if ({cons_read_ready, cons_write_ready, mem_read_valid, mem_write_valid} !== '0) begin
            n_fail++;
            $display("FAIL reset_handshakes: got %b required 0",
                     {cons_read_ready, cons_write_ready, mem_read_valid, mem_write_valid});
        end
        n_checks++;
        if ({cons_read_data, mem_read_address, mem_write_address, mem_write_data} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got %h required 0",
                     {cons_read_data, mem_read_address, mem_write_address, mem_write_data});
        end
        apply_reset();
    endtask

    task automatic test_cold_miss();
        logic [7:0] d;
        int lat, mrv, base;
        bit pok;
        apply_reset();
        base = n_mem_rd;
        do_op(0, 1'b0, 8'h13, 8'h00, d, lat, mrv, pok);
        n_checks++;
        if (lat === -1) begin n_fail++; $display("FAIL miss_timeout: no read_ready on ch0"); end
        n_checks++;
        if (d !== 8'hA5) begin n_fail++; $display("FAIL miss_data: got %h required a5", d); end
        n_checks++;
        if (mrv !== RD_LAT) begin n_fail++; $display("FAIL miss_valid_cycles: got %0d required %0d", mrv, RD_LAT); end
        n_checks++;
        if (pok !== 1'b1) begin n_fail++; $display("FAIL miss_pulse: got %b required 1", pok); end
        n_checks++;
        if (n_mem_rd !== base + 1) begin n_fail++; $display("FAIL miss_mem_reads: got %0d required %0d", n_mem_rd, base + 1); end
        do_op(0, 1'b0, 8'h13, 8'h00, d, lat, mrv, pok);
        n_checks++;
        if (lat !== 2) begin n_fail++; $display("FAIL hit_latency: got %0d required 2", lat); end
        n_checks++;
        if (d !== 8'hA5) begin n_fail++; $display("FAIL hit_data: got %h required a5", d); end
        n_checks++;
        if (n_mem_rd !== base + 1 || mrv !== 0) begin
            n_fail++;
            $display("FAIL hit_no_mem: reads %0d valid_cycles %0d required %0d and 0", n_mem_rd, mrv, base + 1);
        end
    endtask

    task automatic test_write_through();
        logic [7:0] d;
        int lat, mrv, rbase, wbase;
        bit pok;
        rbase = n_mem_rd;
        wbase = n_mem_wr;
        do_op(2, 1'b1, 8'h13, 8'h5C, d, lat, mrv, pok);
        n_checks++;
        if (lat === -1 || pok !== 1'b1) begin n_fail++; $display("FAIL wr_pulse: lat %0d pulse_ok %b required single pulse", lat, pok); end
        n_checks++;
        if (n_mem_wr !== wbase + 1 || last_wr_addr !== 8'h13 || last_wr_data !== 8'h5C) begin
            n_fail++;
            $display("FAIL wr_mem: count %0d addr %h data %h required %0d 13 5c", n_mem_wr, last_wr_addr, last_wr_data, wbase + 1);
        end
        do_op(0, 1'b0, 8'h13, 8'h00, d, lat, mrv, pok);
        n_checks++;
        if (d !== 8'h5C || lat !== 2 || n_mem_rd !== rbase) begin
            n_fail++;
            $display("FAIL wr_then_hit: data %h lat %0d reads %0d required 5c 2 %0d", d, lat, n_mem_rd, rbase);
        end
        do_op(3, 1'b1, 8'h44, 8'h77, d, lat, mrv, pok);
        do_op(1, 1'b0, 8'h44, 8'h00, d, lat, mrv, pok);
        n_checks++;
        if (d !== 8'h77 || n_mem_rd !== rbase + 1) begin
            n_fail++;
            $display("FAIL no_write_allocate: data %h reads %0d required 77 %0d", d, n_mem_rd, rbase + 1);
        end
        n_checks++;
        if (cons_read_data[0 +: DB] !== 8'h5C) begin
            n_fail++;
            $display("FAIL read_data_hold: ch0 data %h required 5c", cons_read_data[0 +: DB]);
        end
    endtask

    task automatic test_eviction();
        logic [7:0] d;
        int lat, mrv, base;
        bit pok;
        apply_reset();
        base = n_mem_rd;
        do_op(0, 1'b0, 8'h03, 8'h00, d, lat, mrv, pok);
        do_op(0, 1'b0, 8'h13, 8'h00, d, lat, mrv, pok);
        do_op(0, 1'b0, 8'h23, 8'h00, d, lat, mrv, pok);
        n_checks++;
        if (n_mem_rd !== base + 3 || d !== mem_model[8'h23]) begin
            n_fail++;
            $display("FAIL evict_fills: reads %0d data %h required %0d %h", n_mem_rd, d, base + 3, mem_model[8'h23]);
        end
        do_op(0, 1'b0, 8'h13, 8'h00, d, lat, mrv, pok);
        n_checks++;
        if (lat !== 2 || n_mem_rd !== base + 3 || d !== mem_model[8'h13]) begin
            n_fail++;
            $display("FAIL evict_keep_way1: lat %0d reads %0d data %h required 2 %0d %h", lat, n_mem_rd, d, base + 3, mem_model[8'h13]);
        end
        do_op(0, 1'b0, 8'h03, 8'h00, d, lat, mrv, pok);
        n_checks++;
        if (n_mem_rd !== base + 4 || d !== mem_model[8'h03]) begin
            n_fail++;
            $display("FAIL evict_way0_gone: reads %0d data %h required %0d %h", n_mem_rd, d, base + 4, mem_model[8'h03]);
        end
    endtask

    task automatic test_arbitration();
        int got;
        apply_reset();
        for (int c = 0; c < CH; c++) cons_read_address[c*AB +: AB] = 8'(8'h30 + c);
        cons_read_valid = '1;
        for (int k = 0; k < 5; k++) begin
            got = -1;
            for (int n = 0; n < 60; n++) begin
                @(negedge clk);
                if (cons_read_ready != '0) begin
                    for (int c = CH - 1; c >= 0; c--) if (cons_read_ready[c]) got = c;
                    break;
                end
            end
            n_checks++;
            if (got !== k % CH) begin
                n_fail++;
                $display("FAIL arb_order_%0d: got ch %0d required ch %0d", k, got, k % CH);
            end
            if (got >= 0) begin
                n_checks++;
                if (cons_read_data[got*DB +: DB] !== mem_model[8'(8'h30 + got)]) begin
                    n_fail++;
                    $display("FAIL arb_data_%0d: got %h required %h", k, cons_read_data[got*DB +: DB], mem_model[8'(8'h30 + got)]);
                end
                cons_read_valid[got] = 1'b0;
                repeat (2) @(negedge clk);
                cons_read_valid[got] = 1'b1;
            end
        end
        cons_read_valid = '0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_held_request();
        bit seen;
        int extra1, served0;
        apply_reset();
        cons_read_address[1*AB +: AB] = 8'h21;
        cons_read_valid[1] = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (cons_read_ready[1]) begin seen = 1'b1; break; end
        end
        n_checks++;
        if (seen !== 1'b1) begin n_fail++; $display("FAIL held_first: no ready on ch1"); end
        cons_read_address[0*AB +: AB] = 8'h05;
        cons_read_valid[0] = 1'b1;
        extra1 = 0;
        served0 = 0;
        repeat (4) begin
            @(negedge clk);
            if (cons_read_ready[1]) extra1++;
            if (cons_read_ready[0]) served0++;
        end
        n_checks++;
        if (extra1 !== 0 || served0 !== 0) begin
            n_fail++;
            $display("FAIL held_release: ch1 extra %0d ch0 served %0d required 0 0", extra1, served0);
        end
        cons_read_valid[1] = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (cons_read_ready[0]) begin seen = 1'b1; break; end
        end
        n_checks++;
        if (seen !== 1'b1 || cons_read_data[0 +: DB] !== mem_model[8'h05]) begin
            n_fail++;
            $display("FAIL held_next_grant: seen %b data %h required 1 %h", seen, cons_read_data[0 +: DB], mem_model[8'h05]);
        end
        cons_read_valid[0] = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid_read();
        logic [7:0] d;
        int lat, mrv, base;
        bit pok, seen;
        apply_reset();
        base = n_mem_rd;
        cons_read_address[0 +: AB] = 8'h13;
        cons_read_valid[0] = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (mem_read_valid) begin seen = 1'b1; break; end
        end
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (seen !== 1'b1 || mem_read_valid !== 1'b0 || mem_read_address !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_mem: seen %b valid %b addr %h required 1 0 00", seen, mem_read_valid, mem_read_address);
        end
        n_checks++;
        if (cons_read_ready !== '0 || cons_write_ready !== '0 || mem_write_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_outputs: rr %b wr %b mwv %b required 0", cons_read_ready, cons_write_ready, mem_write_valid);
        end
        cons_read_valid[0] = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        do_op(0, 1'b0, 8'h13, 8'h00, d, lat, mrv, pok);
        n_checks++;
        if (n_mem_rd !== base + 1 || mrv !== RD_LAT || d !== mem_model[8'h13]) begin
            n_fail++;
            $display("FAIL rst_then_miss: reads %0d valid_cycles %0d data %h required %0d %0d %h",
                     n_mem_rd, mrv, d, base + 1, RD_LAT, mem_model[8'h13]);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        n_mem_rd = 0;
        n_mem_wr = 0;
        last_wr_addr = '0;
        last_wr_data = '0;
        mem_read_ready  = 1'b0;
        mem_read_data   = '0;
        mem_write_ready = 1'b0;
        for (int i = 0; i < 256; i++) mem_model[i] = 8'(i) ^ 8'hB6;
        reset = 1'b1;
        cons_read_valid    = '0;
        cons_write_valid   = '0;
        cons_read_address  = '0;
        cons_write_address = '0;
        cons_write_data    = '0;

        test_reset();
        test_cold_miss();
        test_write_through();
        test_eviction();
        test_arbitration();
        test_held_request();
        test_reset_mid_read();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
